// File: rtl/cls_head_pkg.sv
// Shared types and helpers for the classification head. The saturate helper
// is written generically so the attention/linear blocks can reuse it.
package cls_head_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_POOL,
        ST_FC,
        ST_DONE
    } cls_state_t;

    // FC accumulator width: product width, plus growth over the feature sum,
    // plus room for the pre-shifted bias, plus one guard bit.
    function automatic int acc_w(input int data_width, input int matrix_size,
                                 input int out_shift);
        return 2 * data_width + $clog2(matrix_size) + out_shift + 1;
    endfunction

    // Clamp a wide signed value to a signed range of the given width.
    // The caller truncates the 32-bit result to its own width.
    function automatic logic signed [31:0] saturate(input logic signed [63:0] x,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return 32'(hi);
        end
        if (x < lo) begin
            return 32'(lo);
        end
        return 32'(x);
    endfunction

endpackage

// File: rtl/cls_head_if.sv
// Handshake and data bus between the attention stage and the classification head.
interface cls_head_if #(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 5
);
    localparam int FC_WT_CNT = NUM_CLASSES * MATRIX_SIZE;
    localparam int CLS_W     = $clog2(NUM_CLASSES);

    logic                         start;
    logic signed [DATA_WIDTH-1:0] mat_in [MATRIX_SIZE][MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0] fc_wt  [FC_WT_CNT];
    logic signed [DATA_WIDTH-1:0] fc_bs  [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] logits [NUM_CLASSES];
    logic [CLS_W-1:0]             class_idx;
    logic                         busy;
    logic                         done;

    modport master (
        output start, mat_in, fc_wt, fc_bs,
        input  logits, class_idx, busy, done
    );

    modport slave (
        input  start, mat_in, fc_wt, fc_bs,
        output logits, class_idx, busy, done
    );
endinterface

// File: rtl/cls_head_dot.sv
// Combinational dot product of the pooled feature vector with one class's
// weight row, plus the bias pre-aligned to the accumulator's fixed point.
module cls_dot
    import cls_head_pkg::*;
#(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_SHIFT   = 4
) (
    input  logic signed [DATA_WIDTH-1:0] a    [MATRIX_SIZE],
    input  logic signed [DATA_WIDTH-1:0] w    [MATRIX_SIZE],
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [acc_w(DATA_WIDTH, MATRIX_SIZE, OUT_SHIFT)-1:0] sum
);
    localparam int ACC_W = acc_w(DATA_WIDTH, MATRIX_SIZE, OUT_SHIFT);

    // Sum of products; operands are sign-extended so the width cannot overflow.
    always_comb begin
        sum = ACC_W'(bias) <<< OUT_SHIFT;
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            sum = sum + ACC_W'(a[j]) * ACC_W'(w[j]);
        end
    end
endmodule

// File: rtl/cls_head.sv
// Classification head: captures the attention matrix, mean-pools over rows,
// runs one FC class per cycle through a shared dot product, tracks argmax.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for start
//   LOAD    | capture mat_in, clear accumulators and counters
//   POOL    | add one row per cycle into col_acc; last row -> pooled
//   FC      | one class logit per cycle, running argmax
//   DONE    | one-cycle done pulse
module cls_head
    import cls_head_pkg::*;
#(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 5,
    parameter int OUT_SHIFT   = 4
) (
    input  logic     clk,
    input  logic     rst,
    cls_head_if.slave bus
);
    localparam int FC_BS_CNT = NUM_CLASSES;
    localparam int LOG2_MS   = $clog2(MATRIX_SIZE);
    localparam int COL_W     = DATA_WIDTH + LOG2_MS;
    localparam int CLS_W     = $clog2(NUM_CLASSES);
    localparam int ACC_W     = acc_w(DATA_WIDTH, MATRIX_SIZE, OUT_SHIFT);

    cls_state_t state, state_n;

    logic [LOG2_MS-1:0]           row_cnt;
    logic [CLS_W-1:0]             cls_cnt;
    logic signed [DATA_WIDTH-1:0] mat_mem  [MATRIX_SIZE][MATRIX_SIZE];
    logic signed [COL_W-1:0]      col_acc  [MATRIX_SIZE];
    logic signed [COL_W-1:0]      col_next [MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0] pooled   [MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0] wt_sel   [MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0] bs_sel;
    logic signed [DATA_WIDTH-1:0] logits_q [NUM_CLASSES];
    logic [CLS_W-1:0]             class_q;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [ACC_W-1:0]      dot_sum;
    logic signed [ACC_W-1:0]      fc_shr;
    logic signed [DATA_WIDTH-1:0] fc_sat;
    int                           cls_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; busy/done decode the registered state only.
    always_comb begin
        state_n  = state;
        bus.busy = (state != ST_IDLE);
        bus.done = (state == ST_DONE);
        unique case (state)
            ST_IDLE: if (bus.start) state_n = ST_LOAD;
            ST_LOAD: state_n = ST_POOL;
            ST_POOL: if (row_cnt == LOG2_MS'(MATRIX_SIZE - 1)) state_n = ST_FC;
            ST_FC:   if (cls_cnt == CLS_W'(NUM_CLASSES - 1)) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Column sums including the current row, and the weight row for this class.
    // cls_cnt runs one past the last class after FC, so its select is clamped.
    always_comb begin
        cls_sel = (int'(cls_cnt) < FC_BS_CNT) ? int'(cls_cnt) : 0;
        bs_sel  = bus.fc_bs[cls_sel];
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            col_next[j] = col_acc[j] + COL_W'(mat_mem[row_cnt][j]);
            wt_sel[j]   = bus.fc_wt[cls_sel * MATRIX_SIZE + j];
        end
    end

    cls_dot #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_WIDTH  (DATA_WIDTH),
        .OUT_SHIFT   (OUT_SHIFT)
    ) u_dot (
        .a    (pooled),
        .w    (wt_sel),
        .bias (bs_sel),
        .sum  (dot_sum)
    );

    // Rescale the accumulator and clamp to the logit range.
    always_comb begin
        fc_shr = dot_sum >>> OUT_SHIFT;
        fc_sat = DATA_WIDTH'(saturate(64'(fc_shr), DATA_WIDTH));
    end

    // Datapath: capture, pooling, FC writeback and argmax.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            cls_cnt <= '0;
            class_q <= '0;
            max_val <= '0;
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                col_acc[j] <= '0;
                pooled[j]  <= '0;
                for (int r = 0; r < MATRIX_SIZE; r++) begin
                    mat_mem[r][j] <= '0;
                end
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                logits_q[c] <= '0;
            end
        end else begin
            unique case (state)
                ST_LOAD: begin
                    mat_mem <= bus.mat_in;
                    row_cnt <= '0;
                    cls_cnt <= '0;
                    max_val <= '0;
                    for (int j = 0; j < MATRIX_SIZE; j++) begin
                        col_acc[j] <= '0;
                    end
                end
                ST_POOL: begin
                    row_cnt <= row_cnt + 1'b1;
                    for (int j = 0; j < MATRIX_SIZE; j++) begin
                        col_acc[j] <= col_next[j];
                        // Top DATA_WIDTH bits of the full column sum = floor mean.
                        if (row_cnt == LOG2_MS'(MATRIX_SIZE - 1)) begin
                            pooled[j] <= col_next[j][COL_W-1 -: DATA_WIDTH];
                        end
                    end
                end
                ST_FC: begin
                    cls_cnt           <= cls_cnt + 1'b1;
                    logits_q[cls_sel] <= fc_sat;
                    if (cls_cnt == '0 || fc_sat > max_val) begin
                        max_val <= fc_sat;
                        class_q <= cls_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.logits    = logits_q;
    assign bus.class_idx = class_q;
endmodule
